// File: rtl/wd_retry_ctrl.sv
// Watchdog transaction supervisor: arms/clears the watchdog, launches transmits, debounces match, retries on timeout.
// Optional build macro WD_RETRY_BACKOFF_EN doubles the retry gap for each successive retry.
module wd_retry_ctrl #(
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned MATCH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_tx_done,
  input  logic       i_timeout_event,
  input  logic       i_match_event,
  output logic       o_tx_start,
  output logic       o_wd_rst,
  output logic       o_timer_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_success,
  output logic       o_fail,
  output logic [3:0] o_attempts,
  output logic [2:0] o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  localparam logic [3:0]  MAX_ATTEMPTS = 4'(MAX_RETRY + 1);
  localparam logic [7:0]  MATCH_TGT    = 8'(MATCH_CYCLES);
  localparam logic [16:0] GAP_BASE     = 17'(GAP_CYCLES);

  state_e      state_q;
  logic        arm_q;
  logic [7:0]  match_q;
  logic [16:0] gap_q;
  logic [3:0]  attempts_q;
  logic        tx_start_q;
  logic        wd_rst_q;
  logic        timer_en_q;
  logic        done_q;
  logic        success_q;
  logic        fail_q;

  logic [7:0]  match_d;
  logic        match_hit;
  logic [16:0] gap_len;

  // The match counter saturates at the target so it can never wrap.
  assign match_d   = (match_q == MATCH_TGT) ? match_q : match_q + 8'd1;
  assign match_hit = i_match_event && (match_d == MATCH_TGT);

`ifdef WD_RETRY_BACKOFF_EN
  logic [31:0] gap_shifted;
  // During GAP attempts_q equals k, the index of the retry about to be launched.
  always_comb begin
    gap_shifted = 32'(GAP_CYCLES) << (attempts_q - 4'd1);
    gap_len     = (gap_shifted > 32'h0001_FFFF) ? 17'h1_FFFF : gap_shifted[16:0];
  end
`else
  assign gap_len = GAP_BASE;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      match_q    <= 8'd0;
      gap_q      <= 17'd0;
      attempts_q <= 4'd0;
      tx_start_q <= 1'b0;
      wd_rst_q   <= 1'b0;
      timer_en_q <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else if (i_abort && (state_q != S_IDLE)) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      match_q    <= 8'd0;
      gap_q      <= 17'd0;
      tx_start_q <= 1'b0;
      wd_rst_q   <= 1'b0;
      timer_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            success_q  <= 1'b0;
            fail_q     <= 1'b0;
            attempts_q <= 4'd0;
            wd_rst_q   <= 1'b1;
            arm_q      <= 1'b0;
            state_q    <= S_ARM;
          end
        end
        S_ARM: begin
          if (arm_q) begin
            wd_rst_q   <= 1'b0;
            tx_start_q <= 1'b1;
            attempts_q <= attempts_q + 4'd1;
            state_q    <= S_SEND;
          end else begin
            arm_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_tx_done) begin
            timer_en_q <= 1'b1;
            match_q    <= 8'd0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          match_q <= i_match_event ? match_d : 8'd0;
          // A completed match outranks a timeout arriving on the same edge.
          if (match_hit) begin
            success_q  <= 1'b1;
            done_q     <= 1'b1;
            timer_en_q <= 1'b0;
            state_q    <= S_FIN;
          end else if (i_timeout_event) begin
            timer_en_q <= 1'b0;
            match_q    <= 8'd0;
            gap_q      <= 17'd0;
            if (attempts_q < MAX_ATTEMPTS) begin
              state_q <= S_GAP;
            end else begin
              fail_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_GAP: begin
          if (gap_q == gap_len - 17'd1) begin
            gap_q    <= 17'd0;
            wd_rst_q <= 1'b1;
            arm_q    <= 1'b0;
            state_q  <= S_ARM;
          end else begin
            gap_q <= gap_q + 17'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start  = tx_start_q;
  assign o_wd_rst    = wd_rst_q;
  assign o_timer_en  = timer_en_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_success   = success_q;
  assign o_fail      = fail_q;
  assign o_attempts  = attempts_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_wd_retry_ctrl.sv
// Directed bench for wd_retry_ctrl: results are queued when a transaction is launched and popped on o_done.
`timescale 1ns/1ps
module tb_wd_retry_ctrl;

  localparam int GAP_CYCLES = 1000;
  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_SEND = 2;
  localparam int S_WAIT = 3;
  localparam int S_GAP  = 4;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start, i_abort, i_tx_done, i_timeout_event, i_match_event;
  logic       o_tx_start, o_wd_rst, o_timer_en, o_busy, o_done, o_success, o_fail;
  logic [3:0] o_attempts;
  logic [2:0] o_state_dbg;

  int checks   = 0;
  int errors   = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;
  logic [5:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  wd_retry_ctrl #(.MAX_RETRY(3), .MATCH_CYCLES(4), .GAP_CYCLES(GAP_CYCLES)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_tx_done(i_tx_done), .i_timeout_event(i_timeout_event), .i_match_event(i_match_event),
    .o_tx_start(o_tx_start), .o_wd_rst(o_wd_rst), .o_timer_en(o_timer_en), .o_busy(o_busy),
    .o_done(o_done), .o_success(o_success), .o_fail(o_fail), .o_attempts(o_attempts),
    .o_state_dbg(o_state_dbg)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, count strobes and score any result.
  task automatic tick();
    logic [5:0] res;
    @(posedge i_clk);
    #1;
    if (o_tx_start) tx_cnt++;
    if (o_done) begin
      done_cnt++;
      chk("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        res = exp_q.pop_front();
        chk("result", int'({o_success, o_fail, o_attempts}), int'(res));
      end
    end
  endtask

  task automatic chk_quiet(input string tag, input int att);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_strobes"}, int'({o_tx_start, o_wd_rst, o_timer_en, o_done}), 0);
    chk({tag, "_flags"}, int'({o_success, o_fail}), 0);
    chk({tag, "_attempts"}, int'(o_attempts), att);
    chk({tag, "_state"}, int'(o_state_dbg), S_IDLE);
  endtask

  task automatic wait_tx(input int limit, output int n, output int wdc);
    n = 0;
    wdc = 0;
    do begin
      tick();
      n++;
      if (o_wd_rst) wdc++;
    end while (!o_tx_start && n < limit);
    chk("tx_start_seen", int'(o_tx_start), 1);
  endtask

  task automatic start_txn(output int lat, output int wdc);
    int n, w;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("arm_wd_rst", int'(o_wd_rst), 1);
    chk("arm_attempts_clr", int'(o_attempts), 0);
    chk("arm_state", int'(o_state_dbg), S_ARM);
    wait_tx(8, n, w);
    lat = n + 1;
    wdc = w + 1;
  endtask

  task automatic finish_send(input int dly);
    for (int k = 0; k < dly; k++) tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("in_wait", int'(o_state_dbg), S_WAIT);
    chk("wait_timer_en", int'(o_timer_en), 1);
  endtask

  task automatic abort_now(input string tag, input int att);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk_quiet(tag, att);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, wdc, n, d0, t0, gap;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_tx_done = 1'b0; i_timeout_event = 1'b0; i_match_event = 1'b0;
    repeat (3) tick();
    chk_quiet("reset", 0);
    i_rst = 1'b0;
    tick();

    // First-try success with tx_done two cycles after the launch pulse.
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    d0 = done_cnt;
    start_txn(lat, wdc);
    chk("t1_latency", lat, 3);
    chk("t1_wd_rst_cycles", wdc, 2);
    chk("t1_attempts", int'(o_attempts), 1);
    finish_send(2);
    i_match_event = 1'b1;
    repeat (3) tick();
    chk("t1_no_early_done", done_cnt - d0, 0);
    tick();
    i_match_event = 1'b0;
    chk("t1_done", done_cnt - d0, 1);
    tick();
    chk("t1_busy_after", int'(o_busy), 0);
    chk("t1_success_held", int'(o_success), 1);

    // Every attempt times out: four launches, three gaps, then failure.
    exp_q.push_back({1'b0, 1'b1, 4'd4});
    d0 = done_cnt;
    t0 = tx_cnt;
    start_txn(lat, wdc);
    for (int a = 1; a <= 4; a++) begin
      finish_send(1);
      i_timeout_event = 1'b1;
      tick();
      i_timeout_event = 1'b0;
      if (a < 4) begin
        chk("t2_gap_state", int'(o_state_dbg), S_GAP);
        chk("t2_gap_quiet", int'({o_timer_en, o_wd_rst}), 0);
        gap = GAP_CYCLES;
`ifdef WD_RETRY_BACKOFF_EN
        gap = GAP_CYCLES << (a - 1);
        if (gap > 'h1FFFF) gap = 'h1FFFF;
`endif
        wait_tx(gap + 10, n, wdc);
        chk("t2_gap_len", n, gap + 2);
        chk("t2_wd_rst_cycles", wdc, 2);
        chk("t2_attempts", int'(o_attempts), a + 1);
      end
    end
    chk("t2_tx_pulses", tx_cnt - t0, 4);
    chk("t2_done", done_cnt - d0, 1);
    tick();
    chk("t2_fail_held", int'({o_busy, o_success, o_fail}), 1);

    // Glitchy match: 3 high, 1 low, then 4 high.
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    d0 = done_cnt;
    start_txn(lat, wdc);
    finish_send(0);
    i_match_event = 1'b1;
    repeat (3) tick();
    i_match_event = 1'b0;
    tick();
    chk("t3_still_wait", int'(o_state_dbg), S_WAIT);
    i_match_event = 1'b1;
    repeat (3) tick();
    chk("t3_no_early_done", done_cnt - d0, 0);
    tick();
    i_match_event = 1'b0;
    chk("t3_done", done_cnt - d0, 1);
    tick();

    // Timeout on the 3rd match cycle retries; timeout on the 4th loses to success.
    exp_q.push_back({1'b1, 1'b0, 4'd2});
    d0 = done_cnt;
    start_txn(lat, wdc);
    finish_send(0);
    i_match_event = 1'b1;
    repeat (2) tick();
    i_timeout_event = 1'b1;
    tick();
    i_timeout_event = 1'b0;
    i_match_event = 1'b0;
    chk("t4_partial_gap", int'(o_state_dbg), S_GAP);
    chk("t4_no_done", done_cnt - d0, 0);
    wait_tx(GAP_CYCLES + 10, n, wdc);
    chk("t4_retry_attempts", int'(o_attempts), 2);
    finish_send(0);
    i_match_event = 1'b1;
    repeat (3) tick();
    i_timeout_event = 1'b1;
    tick();
    i_timeout_event = 1'b0;
    i_match_event = 1'b0;
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_success", int'({o_success, o_fail}), 2);
    tick();

    // Abort in each busy state, and on the success cycle.
    d0 = done_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t5_in_arm", int'(o_state_dbg), S_ARM);
    abort_now("t5_arm", 0);
    start_txn(lat, wdc);
    abort_now("t5_send", 1);
    start_txn(lat, wdc);
    finish_send(0);
    abort_now("t5_wait", 1);
    start_txn(lat, wdc);
    finish_send(0);
    i_timeout_event = 1'b1;
    tick();
    i_timeout_event = 1'b0;
    repeat (5) tick();
    chk("t5_in_gap", int'(o_state_dbg), S_GAP);
    abort_now("t5_gap", 1);
    start_txn(lat, wdc);
    finish_send(0);
    i_match_event = 1'b1;
    repeat (3) tick();
    abort_now("t5_succ_cycle", 1);
    i_match_event = 1'b0;
    tick();
    chk("t5_no_done", done_cnt - d0, 0);
    exp_q.push_back({1'b1, 1'b0, 4'd1});
    start_txn(lat, wdc);
    chk("t5_fresh_latency", lat, 3);
    finish_send(1);
    i_match_event = 1'b1;
    repeat (4) tick();
    i_match_event = 1'b0;
    chk("t5_fresh_done", done_cnt - d0, 1);
    tick();

    // Start and watchdog events outside their states are ignored; reset in WAIT.
    start_txn(lat, wdc);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t6_start_ignored", int'(o_attempts), 1);
    chk("t6_still_send", int'(o_state_dbg), S_SEND);
    i_timeout_event = 1'b1;
    i_match_event = 1'b1;
    tick();
    i_timeout_event = 1'b0;
    i_match_event = 1'b0;
    chk("t6_events_ignored", int'(o_state_dbg), S_SEND);
    finish_send(0);
    i_rst = 1'b1;
    tick();
    chk_quiet("t6_rst_wait", 0);
    i_rst = 1'b0;
    tick();
    chk("t6_idle_after_rst", int'(o_busy), 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
